accel_sample_fifo: RTL and testbench
====================================

# accel_sample_fifo

Memory-mapped capture buffer between `accelerometer_reader` and the picorv32 bus. It latches each new Y/Z sample pair into a DEPTH-entry FIFO, exposes data, status and control registers at BASE_ADDR, and raises a level-triggered interrupt when the fill level reaches a programmable threshold. The system top ORs `sel_ready`/`sel_rdata` into the core's `mem_ready`/`mem_rdata` path, alongside RAM and the out_byte/seven-segment port.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, 2..16.
- `BASE_ADDR`, 32'h1000_0010, word-aligned base of the 16-byte register window.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `sample_strobe`  in  1  one-cycle pulse: `y_value`/`z_value` hold a new pair.
- `y_value`  in  16  accelerometer Y sample.
- `z_value`  in  16  accelerometer Z sample.
- `mem_valid`  in  1  core bus request.
- `mem_addr`  in  32  core bus address.
- `mem_wdata`  in  32  core write data.
- `mem_wstrb`  in  4  byte strobes; 0 means read.
- `sel_ready`  out  1  access completion; reset 0.
- `sel_rdata`  out  32  read data; valid when `sel_ready`=1, else 0; reset 0.
- `irq`  out  1  FIFO-level interrupt; reset 0.

## Operation
- Hit: `mem_valid && mem_addr[31:4]==BASE_ADDR[31:4] && !sel_ready`. Access is accepted on the hit cycle.
- Offset 0x0, DATA (RO): a read returns `{y,z}` of the head entry and pops it. If the FIFO is empty, it returns 0 with no pop. Writes are ignored.
- Offset 0x4, STATUS: [4:0] count, [16] empty, [17] full, [18] overflow (sticky). Writing 1 to bit 18 clears overflow.
- Offset 0x8, CTRL (RW): [0] capture_en, [1] irq_en, [12:8] irq_level. Reset value is 0x0000_0001.
- Offset 0xC, FLUSH (WO): any write empties the FIFO and clears overflow. Reads return 0.
- Push: on `sample_strobe && capture_en`, `{y_value,z_value}` is written at the tail.
  - When the FIFO is full with no pop in the same cycle, the sample is dropped and overflow is set.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the pop frees the slot, so the push succeeds and overflow is not set.
  - When empty, the read returns 0 and the new sample is stored, giving count 1.
- FLUSH in the same cycle as a push: flush wins and count ends at 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is a separate 5-bit register, 0..DEPTH.
- Interrupt: `irq = irq_en && count >= max(irq_level,1)`. An irq_level above DEPTH never fires. The interrupt is level-sensitive and clears only by draining the FIFO, changing CTRL, or flushing.
- Partial byte strobes on CTRL update only the strobed bytes. Reserved bits read 0.
- Reset mid-operation clears pointers, count, overflow, CTRL (to its reset value), `sel_ready`, `sel_rdata` and `irq` immediately. Any in-flight access is lost.

## Timing
- Bus latency is 1 cycle. The hit is registered at edge N, and `sel_ready`=1 plus `sel_rdata` are valid during cycle N+1 for exactly one cycle.
- A request still held in N+1 is not re-accepted, because of `!sel_ready`.
- Register write, pop and flush commit at the edge that accepts the access.
- Push commits at the edge sampling `sample_strobe`. Count and STATUS reflect it from the next cycle.
- `irq` is registered: it asserts 1 cycle after count or CTRL satisfies the condition and deasserts 1 cycle after it stops.
- Back-to-back accesses occur at most every 2 cycles.

## Configuration
- `ACCEL_FIFO_IRQ_EN` defined: interrupt logic, CTRL[1] and CTRL[12:8] are implemented as above.
- `ACCEL_FIFO_IRQ_EN` undefined:
  - `irq` is tied 0.
  - CTRL[1] and CTRL[12:8] are not stored and read 0.
  - Writes to those bits are ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset, then 3 strobes with (Y,Z)=(0x0001,0x0002),(0x0003,0x0004),(0x0005,0x0006) -> STATUS count=3. Three DATA reads return 0x00010002, 0x00030004, 0x00050006. A fourth read returns 0 and STATUS=0x0001_0000.
- DEPTH=8 with 9 strobes and no reads -> STATUS=0x0006_0008 (full, overflow). Head reads the first sample. Write 0x0004_0000 to STATUS -> overflow clears.
- FIFO full, with a DATA read accepted in the same cycle as a strobe -> the read returns the oldest entry, count stays 8, overflow stays 0.
- CTRL=0x0000_0303 (irq_en, level 3) -> `irq` rises 1 cycle after the 3rd push and falls 1 cycle after the pop that leaves count 2. With the macro undefined, `irq` stays 0 and CTRL reads back 0x0000_0001.
- With 5 entries, FLUSH write coincident with a strobe -> count=0 and empty=1 the next cycle. Subsequent DATA reads return 0.
- Assert `resetn`=0 mid-access, while `sel_ready` is pending with count 4 -> `sel_ready`, `sel_rdata` and `irq` are 0 immediately, and after release STATUS=0x0001_0000 and CTRL=0x0000_0001.

Source files
------------

// File: rtl/accel_sample_fifo.sv
// Capture FIFO for accelerometer Y/Z sample pairs with a 16-byte register window on the picorv32 bus.
// Define ACCEL_FIFO_IRQ_EN to build the fill-level interrupt and its CTRL fields.
module accel_sample_fifo #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0010
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sample_strobe,
    input  logic [15:0] y_value,
    input  logic [15:0] z_value,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        sel_ready,
    output logic [31:0] sel_rdata,
    output logic        irq
);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic          capture_en;
    logic          irq_en;
    logic [4:0]    irq_level;

    logic        hit;
    logic        is_wr;
    logic [1:0]  offset;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        flush;
    logic        status_wr;
    logic        ctrl_wr;
    logic        ovf_set;
    logic [31:0] rdata_next;
    logic        unused_bits;

    assign hit       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !sel_ready;
    assign is_wr     = |mem_wstrb;
    assign offset    = mem_addr[3:2];
    assign empty     = (count == 5'd0);
    assign full      = (count == DEPTH_CNT);
    assign pop       = hit && !is_wr && (offset == 2'd0) && !empty;
    assign flush     = hit && is_wr && (offset == 2'd3);
    assign status_wr = hit && is_wr && (offset == 2'd1);
    assign ctrl_wr   = hit && is_wr && (offset == 2'd2);
    assign push_req  = sample_strobe && capture_en;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;

    assign unused_bits = ^{mem_wdata, mem_addr[1:0], mem_wstrb[3]};

    always_comb begin
        rdata_next = '0;
        if (!is_wr) begin
            case (offset)
                2'd0:    rdata_next = empty ? 32'd0 : mem[rd_ptr];
                2'd1:    rdata_next = {13'd0, overflow, full, empty, 11'd0, count};
                2'd2:    rdata_next = {19'd0, irq_level, 6'd0, irq_en, capture_en};
                default: rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {y_value, z_value};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_ready  <= 1'b0;
            sel_rdata  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            capture_en <= 1'b1;
        end else begin
            sel_ready <= hit;
            sel_rdata <= hit ? rdata_next : 32'd0;
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                count <= count + 5'(push) - 5'(pop);
                // A new overflow in the clearing cycle takes precedence so no drop goes unreported.
                if (ovf_set) begin
                    overflow <= 1'b1;
                end else if (status_wr && mem_wstrb[2] && mem_wdata[18]) begin
                    overflow <= 1'b0;
                end
            end
            if (ctrl_wr && mem_wstrb[0]) begin
                capture_en <= mem_wdata[0];
            end
        end
    end

`ifdef ACCEL_FIFO_IRQ_EN
    logic [4:0] level_eff;

    assign level_eff = (irq_level == 5'd0) ? 5'd1 : irq_level;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en    <= 1'b0;
            irq_level <= '0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr && mem_wstrb[0]) begin
                irq_en <= mem_wdata[1];
            end
            if (ctrl_wr && mem_wstrb[1]) begin
                irq_level <= mem_wdata[12:8];
            end
            irq <= irq_en && (count >= level_eff);
        end
    end
`else
    assign irq_en    = 1'b0;
    assign irq_level = '0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_accel_sample_fifo.sv
// Directed bench for accel_sample_fifo: FIFO order, status flags, overflow, flush, interrupt and reset.
module tb_accel_sample_fifo;
    localparam logic [31:0] A_DATA   = 32'h1000_0010;
    localparam logic [31:0] A_STATUS = 32'h1000_0014;
    localparam logic [31:0] A_CTRL   = 32'h1000_0018;
    localparam logic [31:0] A_FLUSH  = 32'h1000_001C;
`ifdef ACCEL_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_strobe = 1'b0;
    logic [15:0] y_value = '0;
    logic [15:0] z_value = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] rd;

    accel_sample_fifo #(.DEPTH(8), .BASE_ADDR(32'h1000_0010)) dut (
        .clk(clk), .resetn(resetn), .sample_strobe(sample_strobe),
        .y_value(y_value), .z_value(z_value), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .sel_ready(sel_ready), .sel_rdata(sel_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus access, optionally with a sample strobe in the cycle the access is accepted.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input bit with_strobe, input logic [15:0] y, input logic [15:0] z,
                       output logic [31:0] rdata);
        bit got = 1'b0;
        rdata = '0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        if (with_strobe) begin
            sample_strobe = 1'b1; y_value = y; z_value = z;
        end
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            sample_strobe = 1'b0;
            if (sel_ready) begin
                got = 1'b1;
                rdata = sel_rdata;
            end
        end
        mem_valid = 1'b0; mem_wstrb = '0;
        if (!got) check("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rdata);
        bus(addr, 32'd0, 4'h0, 1'b0, 16'd0, 16'd0, rdata);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] dummy;
        bus(addr, wdata, wstrb, 1'b0, 16'd0, 16'd0, dummy);
    endtask

    task automatic strobe(input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_strobe = 1'b1; y_value = y; z_value = z;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, sel_ready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_reg(A_STATUS, rd); check("rst_status", rd, 32'h0001_0000);
        rd_reg(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0000_0001);

        // Basic ordering
        strobe(16'h0001, 16'h0002);
        strobe(16'h0003, 16'h0004);
        strobe(16'h0005, 16'h0006);
        rd_reg(A_STATUS, rd); check("cnt3_status", rd, 32'h0000_0003);
        rd_reg(A_DATA, rd);   check("pop1", rd, 32'h0001_0002);
        rd_reg(A_DATA, rd);   check("pop2", rd, 32'h0003_0004);
        rd_reg(A_DATA, rd);   check("pop3", rd, 32'h0005_0006);
        rd_reg(A_DATA, rd);   check("pop_empty", rd, 32'h0000_0000);
        rd_reg(A_STATUS, rd); check("empty_status", rd, 32'h0001_0000);

        // Overflow
        for (int i = 0; i < 9; i++) strobe(16'(16'h0100 + i), 16'(16'h0200 + i));
        rd_reg(A_STATUS, rd); check("ovf_status", rd, 32'h0006_0008);
        rd_reg(A_DATA, rd);   check("ovf_head", rd, 32'h0100_0200);
        rd_reg(A_STATUS, rd); check("ovf_after_pop", rd, 32'h0004_0007);
        wr_reg(A_STATUS, 32'h0004_0000, 4'hF);
        rd_reg(A_STATUS, rd); check("ovf_cleared", rd, 32'h0000_0007);
        rd_reg(A_DATA, rd);   check("ovf_second", rd, 32'h0101_0201);
        wr_reg(A_FLUSH, 32'd0, 4'hF);
        rd_reg(A_STATUS, rd); check("flush_status", rd, 32'h0001_0000);

        // Full FIFO: pop and push in the same cycle
        for (int i = 0; i < 8; i++) strobe(16'(16'h0010 + i), 16'(16'h0020 + i));
        rd_reg(A_STATUS, rd); check("full_status", rd, 32'h0002_0008);
        bus(A_DATA, 32'd0, 4'h0, 1'b1, 16'hAAAA, 16'hBBBB, rd);
        check("full_simul_data", rd, 32'h0010_0020);
        rd_reg(A_STATUS, rd); check("full_simul_status", rd, 32'h0002_0008);
        rd_reg(A_DATA, rd);   check("full_next", rd, 32'h0011_0021);
        for (int i = 0; i < 6; i++) rd_reg(A_DATA, rd);
        rd_reg(A_DATA, rd);   check("full_tail", rd, 32'hAAAA_BBBB);

        // Empty FIFO: pop and push in the same cycle
        bus(A_DATA, 32'd0, 4'h0, 1'b1, 16'h1234, 16'h5678, rd);
        check("empty_simul_data", rd, 32'h0000_0000);
        rd_reg(A_STATUS, rd); check("empty_simul_status", rd, 32'h0000_0001);
        rd_reg(A_DATA, rd);   check("empty_simul_pop", rd, 32'h1234_5678);

        // Interrupt level 3
        wr_reg(A_CTRL, 32'h0000_0303, 4'hF);
        rd_reg(A_CTRL, rd); check("ctrl_rb", rd, IRQ_ON ? 32'h0000_0303 : 32'h0000_0001);
        strobe(16'h0000, 16'h0001);
        strobe(16'h0000, 16'h0002);
        @(negedge clk);
        check("irq_cnt2", {31'd0, irq}, 32'd0);
        strobe(16'h0000, 16'h0003);
        check("irq_same_cycle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
        rd_reg(A_DATA, rd);
        check("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        wr_reg(A_CTRL, 32'hFFFF_FF00, 4'b0010);
        rd_reg(A_CTRL, rd); check("ctrl_partial", rd, IRQ_ON ? 32'h0000_1F03 : 32'h0000_0001);
        strobe(16'h0000, 16'h0004);
        repeat (2) @(negedge clk);
        check("irq_level_hi", {31'd0, irq}, 32'd0);
        wr_reg(A_CTRL, 32'h0000_0001, 4'hF);

        // Flush against a strobe
        wr_reg(A_FLUSH, 32'd0, 4'hF);
        for (int i = 0; i < 5; i++) strobe(16'(i), 16'(i));
        rd_reg(A_STATUS, rd); check("five_status", rd, 32'h0000_0005);
        bus(A_FLUSH, 32'd0, 4'hF, 1'b1, 16'h7777, 16'h8888, rd);
        rd_reg(A_STATUS, rd); check("flush_push_status", rd, 32'h0001_0000);
        rd_reg(A_DATA, rd);   check("flush_push_data", rd, 32'h0000_0000);

        // Reset while a read response is pending
        wr_reg(A_CTRL, 32'h0000_0103, 4'hF);
        for (int i = 0; i < 4; i++) strobe(16'(16'h0040 + i), 16'(i));
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = A_STATUS; mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("pre_rst_ready", {31'd0, sel_ready}, 32'd1);
        check("pre_rst_irq", {31'd0, irq}, {31'd0, IRQ_ON});
        resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("rst_async_ready", {31'd0, sel_ready}, 32'd0);
        check("rst_async_rdata", sel_rdata, 32'd0);
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rd_reg(A_STATUS, rd); check("post_rst_status", rd, 32'h0001_0000);
        rd_reg(A_CTRL, rd);   check("post_rst_ctrl", rd, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
